// File: rtl/aes_shares_word_loader.sv
// Word-serial input front end for the masked AES-128 top.
//
// Collects a 32-bit valid/ready word stream into the full shared key and
// plaintext buses and presents them together on a valid/ready output. The
// output side connects straight to the AES top's input handshake.
//
// Word order within a block is key words first, then plaintext words. Both
// are share-major: word index i = 4*s + w lands at [32*i +: 32], which is
// [128*s + 32*w +: 32]. A block whose first word carries in_key_reuse=1 skips
// the key words and reuses the stored key, provided a complete key is held.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst                  asynchronous active-high reset
//   in_valid/in_ready    word stream handshake
//   in_data              share word
//   in_key_reuse         sampled with the first word of a block only
//   out_valid/out_ready  assembled block handshake (to the AES top)
//   out_shares_key       key shares, share s at [128*s +: 128]
//   out_shares_plaintext plaintext shares, same layout
//   key_valid            a complete key is stored and can be reused
module aes_shares_word_loader #(
    parameter int unsigned d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_key_reuse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*d-1:0] out_shares_key,
    output logic [128*d-1:0] out_shares_plaintext,
    output logic             key_valid
);

    localparam int unsigned NumWords = 4 * d;
    localparam int unsigned CntW     = $clog2(NumWords);
    localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoadKey,
        StLoadPt,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [128*d-1:0] key_q, key_d;
    logic [128*d-1:0] pt_q, pt_d;
    logic             key_valid_q, key_valid_d;
    logic             xfer;

    // Ready is forced low while reset is held, even though the state
    // register already reads Idle.
    assign in_ready             = ~rst & (state_q != StFull);
    assign xfer                 = in_valid & in_ready;
    assign out_valid            = (state_q == StFull);
    assign out_shares_key       = key_q;
    assign out_shares_plaintext = pt_q;
    assign key_valid            = key_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        pt_d        = pt_q;
        key_valid_d = key_valid_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    cnt_d = CntW'(1);
                    if (in_key_reuse && key_valid_q) begin
                        pt_d[31:0] = in_data;
                        state_d    = StLoadPt;
                    end else begin
                        // A reuse request without a stored key falls back to
                        // a full key load.
                        key_d[31:0] = in_data;
                        key_valid_d = 1'b0;
                        state_d     = StLoadKey;
                    end
                end
            end

            StLoadKey: begin
                if (xfer) begin
                    key_d[32*cnt_q +: 32] = in_data;
                    if (cnt_q == LastWord) begin
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StLoadPt;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StLoadPt: begin
                if (xfer) begin
                    pt_d[32*cnt_q +: 32] = in_data;
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = StFull;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StFull: begin
                if (out_ready) begin
                    // Plaintext is not kept after hand-off; the key is.
                    pt_d    = '0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            key_valid_q <= key_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_shares_word_loader.sv
module tb_aes_shares_word_loader;

    localparam int unsigned D = 2;
    localparam int unsigned W = 128 * D;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_key_reuse;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_shares_key;
    logic [W-1:0] out_shares_plaintext;
    logic         key_valid;

    int checks   = 0;
    int failures = 0;
    int xfer_count = 0;

    aes_shares_word_loader #(.d(D)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_data              (in_data),
        .in_key_reuse         (in_key_reuse),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_shares_key       (out_shares_key),
        .out_shares_plaintext (out_shares_plaintext),
        .key_valid            (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) xfer_count <= xfer_count + 1;
    end

    // Eight consecutive words start, start+1, ... packed LSW first.
    function automatic logic [W-1:0] seq_bus(input logic [31:0] start);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = start + 32'(i);
        return b;
    endfunction

    // Starts and ends on a falling edge; the word transfers on the rising
    // edge in between once in_ready is seen high.
    task automatic send_word(input logic [31:0] w, input logic reuse);
        logic rdy;
        int   n;
        n = 0;
        in_valid     = 1'b1;
        in_data      = w;
        in_key_reuse = reuse;
        forever begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_word_timeout word=%h", w);
                break;
            end
        end
        in_valid     = 1'b0;
        in_key_reuse = 1'b0;
    endtask

    task automatic check_bus(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_key_reuse = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("reset_in_ready_held", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("reset_in_ready_after", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_key_valid", key_valid, 1'b0);
        check_bus("reset_key", out_shares_key, '0);
        check_bus("reset_pt", out_shares_plaintext, '0);
        @(negedge clk);
    endtask

    task automatic test_full_load;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) send_word(32'(i), 1'b0);
        check_bit("full_out_valid_rise", out_valid, 1'b1);
        check_bit("full_in_ready_low", in_ready, 1'b0);
        check_bus("full_key_literal", out_shares_key,
                  256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        check_bus("full_pt_literal", out_shares_plaintext,
                  256'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009);
        check_bit("full_key_valid", key_valid, 1'b1);
        @(negedge clk);
        check_bit("full_out_valid_one_cycle", out_valid, 1'b0);
        check_bus("full_pt_zeroised", out_shares_plaintext, '0);
        check_bus("full_key_kept", out_shares_key, seq_bus(32'h1));
        check_bit("full_in_ready_back", in_ready, 1'b1);
    endtask

    task automatic test_key_reuse;
        out_ready = 1'b0;
        send_word(32'hA0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            check_bit("reuse_no_early_valid", out_valid, 1'b0);
            send_word(32'hA0 + 32'(i), 1'b1);
        end
        check_bit("reuse_out_valid", out_valid, 1'b1);
        check_bus("reuse_key_unchanged", out_shares_key, seq_bus(32'h1));
        check_bus("reuse_pt", out_shares_plaintext,
                  256'h000000a7_000000a6_000000a5_000000a4_000000a3_000000a2_000000a1_000000a0);
    endtask

    task automatic test_backpressure;
        logic [31:0] start;
        start = 32'(xfer_count);
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bus("bp_pt_stable", out_shares_plaintext, seq_bus(32'hA0));
            check_bus("bp_key_stable", out_shares_key, seq_bus(32'h1));
        end
        checks++;
        if (32'(xfer_count) != start) begin
            failures++;
            $display("FAIL bp_word_consumed got=%0d want=%0d", xfer_count, start);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("bp_release_out_valid", out_valid, 1'b0);
        check_bus("bp_release_pt_zero", out_shares_plaintext, '0);
        check_bus("bp_release_key", out_shares_key, seq_bus(32'h1));
        check_bit("bp_release_key_valid", key_valid, 1'b1);
    endtask

    task automatic test_reuse_without_key;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send_word(32'(i), 1'b1);
            if (i == 7) check_bit("nokey_kv_after7", key_valid, 1'b0);
            if (i == 8) check_bit("nokey_kv_after8", key_valid, 1'b1);
            if (i == 15) check_bit("nokey_not_done_15", out_valid, 1'b0);
        end
        check_bit("nokey_out_valid", out_valid, 1'b1);
        check_bus("nokey_key", out_shares_key, seq_bus(32'h1));
        check_bus("nokey_pt", out_shares_plaintext, seq_bus(32'h9));
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_word(32'h50 + 32'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_bit("arst_in_ready", in_ready, 1'b0);
        check_bit("arst_out_valid", out_valid, 1'b0);
        check_bit("arst_key_valid", key_valid, 1'b0);
        check_bus("arst_key", out_shares_key, '0);
        check_bus("arst_pt", out_shares_plaintext, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) send_word(32'h100 + 32'(i), 1'b0);
        check_bit("arst_reload_valid", out_valid, 1'b1);
        check_bus("arst_reload_key", out_shares_key, seq_bus(32'h100));
        check_bus("arst_reload_pt", out_shares_plaintext, seq_bus(32'h108));
        @(negedge clk);
    endtask

    task automatic test_gapped_load;
        int start;
        start = xfer_count;
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            send_word(32'(i), 1'b0);
        end
        // Idle a few cycles with out_ready low; nothing must move.
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_bit("gap_out_valid", out_valid, 1'b1);
        check_bus("gap_key", out_shares_key, seq_bus(32'h1));
        check_bus("gap_pt", out_shares_plaintext, seq_bus(32'h9));
        checks++;
        if (xfer_count - start != 16) begin
            failures++;
            $display("FAIL gap_xfer_count got=%0d want=16", xfer_count - start);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_bus("gap_pt_zero", out_shares_plaintext, '0);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_full_load();
        test_key_reuse();
        test_backpressure();
        test_reuse_without_key();
        test_async_reset();
        test_gapped_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
